bias_add_relu_stage: RTL and testbench
======================================

// Module: bias_add_relu_stage
// PURPOSE
//  Consumer of the per-layer BIAS_layerXX_* constant bundles. Takes the N_adder_tree packed 18-bit partial sums from the adder trees.
//  Adds the matching bias lane, saturates to 18 bits, applies optional ReLU, and forwards the result to the next layer's input buffer.
//  Two-stage valid/ready pipeline with full backpressure. Counts output pixels and flags end-of-frame.
// PARAMETERS
//  N_adder_tree   16    number of parallel lanes (output channels per beat)
//  DATA_W         18    lane width, two's complement, same Q-format as bias
//  RELU_EN        1     1: clamp negative results to 0; 0: pass signed result
//  PIX_PER_FRAME  196   output handshakes per frame (14x14 feature map)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous, active-high reset
//  bias_q     in   N_adder_tree*18    static bias bundle; lane i = bits [18*(i+1)-1:18*i]
//  in_valid   in   1                  adder-tree sums valid
//  in_ready   out  1                  stage can accept in_data this cycle
//  in_data    in   N_adder_tree*18    packed sums, same lane packing as bias_q
//  out_valid  out  1                  out_data valid
//  out_ready  in   1                  downstream accepts out_data
//  out_data   out  N_adder_tree*18    biased, saturated, (ReLU'd) lanes
//  sat_flag   out  1                  qualified by out_valid: >=1 lane of this beat saturated
//  frame_done out  1                  one-cycle pulse after last pixel of frame handshaken
// BEHAVIOUR
//  - Handshake: transfer when valid&ready on the same edge. Once out_valid rises, out_data/sat_flag stay stable until out_ready.
//  - S1 register: sum_i = sext(in_i) + sext(bias_i), DATA_W+1 bits, per lane.
//  - S2 register: saturate sum_i to [-2^17, 2^17-1].
//    - Overflow -> 0x1FFFF; underflow -> 0x20000.
//    - sat_flag = OR of lane saturations.
//    - RELU_EN=1: negative -> 0. Saturation is evaluated before ReLU, so an underflow still sets sat_flag.
//  - Latency: 2 cycles from an input handshake to out_valid with no stall. Throughput is 1 beat/cycle.
//  - Flow control:
//    - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv.
//    - in_ready = s1_adv & !rst (combinational).
//    - Bubbles collapse. Maximum 2 beats in flight. Order is preserved. No drop, no duplication.
//  - Pixel counter:
//    - Width is clog2(PIX_PER_FRAME). It increments on each output handshake.
//    - On the handshake where count == PIX_PER_FRAME-1, the counter wraps to 0 and frame_done pulses high on the next cycle only.
//  - Simultaneous input and output handshakes on a full pipe are legal. The pipe advances as a shift.
//  - bias_q is treated as constant. A change is picked up by the next beat entering S1; no resync is provided.
//  - Reset (any cycle, including mid-frame):
//    - Next cycle: s1_valid = s2_valid = 0, out_valid = 0, out_data = 0, sat_flag = 0, frame_done = 0, pixel count = 0.
//    - In-flight beats are discarded. in_ready is 0 while rst is high and 1 on the first cycle after.
// STRUCTURE
//  - Shared package layer_pkg: DATA_W=18, SAT_MAX=18'h1FFFF, SAT_MIN=18'h20000, and the lane slice helper function.
//  - One sub-module, bias_sat_lane:
//    - Combinational per-lane S2 logic: saturate + ReLU + lane sat bit.
//    - Generated N_adder_tree times.
//  - Pipeline registers, handshake, and counter live in the top module.
// TESTING
//  1. Lane 0 bias=18'd100, in=18'd50, out_ready=1 -> out_data lane0 = 18'd150 two cycles later; sat_flag=0.
//  2. Lane 1 bias=-1616 (18'h3F9B0), in=1000:
//     - RELU_EN=1 -> lane1 = 0, sat_flag=0.
//     - RELU_EN=0 -> lane1 = 18'h3FD98.
//  3. Overflow and underflow: in=18'h1FFFF, bias=100 -> lane=18'h1FFFF, sat_flag=1. in=18'h20000, bias=-1616, RELU_EN=0 -> 18'h20000, sat_flag=1.
//  4. Backpressure: in_valid=1 with an incrementing pattern, out_ready=0 for 5 cycles.
//     - Exactly 2 beats are accepted, then in_ready=0.
//     - The held out_data is stable.
//     - After release, all beats exit in order with no gaps or duplicates.
//  5. PIX_PER_FRAME=4, 9 back-to-back beats -> frame_done pulses 1 cycle after the 4th and 8th output handshakes; count=1 at the end.
//  6. Assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0, frame_done=0, count=0.
//     The first post-reset beat emerges after 2 cycles with correct data.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared layer constants: lane width, saturation limits, packed-lane slice helper.
// Latency: none (types/constants only).
// Backpressure: none.
package layer_pkg;

    localparam int DATA_W    = 18;
    localparam int MAX_LANES = 64;
    localparam int BUS_W     = MAX_LANES * DATA_W;

    localparam logic [DATA_W-1:0] SAT_MAX = 18'h1FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 18'h20000;

    typedef logic [BUS_W-1:0] lane_bus_t;

    // Lane idx of a packed bundle; lane i occupies bits [DATA_W*(i+1)-1 : DATA_W*i].
    function automatic logic [DATA_W-1:0] lane_slice(input lane_bus_t bus, input int idx);
        return bus[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/bias_sat_lane.sv
// One lane of the second stage: saturate a widened sum to DATA_W, then optional ReLU.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module bias_sat_lane
    import layer_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic [DATA_W:0]   i_sum,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_sat
);

    logic              w_ovf;
    logic              w_unf;
    logic [DATA_W-1:0] w_sat_dat;

    // Clamp on sign/carry disagreement; ReLU sees the clamped value so an underflow still flags.
    always_comb begin
        w_ovf = !i_sum[DATA_W] &&  i_sum[DATA_W-1];
        w_unf =  i_sum[DATA_W] && !i_sum[DATA_W-1];
        if (w_ovf) begin
            w_sat_dat = SAT_MAX;
        end else if (w_unf) begin
            w_sat_dat = SAT_MIN;
        end else begin
            w_sat_dat = i_sum[DATA_W-1:0];
        end
        o_sat = w_ovf | w_unf;
        o_dat = (RELU_EN && w_sat_dat[DATA_W-1]) ? '0 : w_sat_dat;
    end

endmodule

// File: rtl/bias_add_relu_stage.sv
// Adds per-lane bias to adder-tree sums, saturates, optional ReLU; counts pixels per frame.
// Latency: 2 cycles input handshake to out_valid, 1 beat/cycle throughput.
// Backpressure: two-slot shift pipe; in_ready drops only when both stages hold data and out_ready is low.
module bias_add_relu_stage #(
    parameter int N_adder_tree  = 16,
    parameter int DATA_W        = 18,
    parameter bit RELU_EN       = 1'b1,
    parameter int PIX_PER_FRAME = 196
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_adder_tree*DATA_W-1:0] bias_q,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic                         sat_flag,
    output logic                         frame_done
);
    import layer_pkg::*;

    localparam int BUS   = N_adder_tree * DATA_W;
    localparam int CNT_W = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;

    logic                              w_s1_adv;
    logic                              w_s2_adv;
    logic                              w_out_hs;
    logic                              w_last_pix;
    lane_bus_t                         w_in_ext;
    lane_bus_t                         w_bias_ext;
    logic [N_adder_tree-1:0][DATA_W:0] w_s1_sum_nxt;
    logic [BUS-1:0]                    w_s2_dat_nxt;
    logic [N_adder_tree-1:0]           w_lane_sat;

    logic                              r_s1_vld;
    logic [N_adder_tree-1:0][DATA_W:0] r_s1_sum;
    logic                              r_s2_vld;
    logic [BUS-1:0]                    r_s2_dat;
    logic                              r_s2_sat;
    logic [CNT_W-1:0]                  r_pix_cnt;
    logic                              r_frame_done;

    assign w_s2_adv   = !r_s2_vld || out_ready;
    assign w_s1_adv   = !r_s1_vld || w_s2_adv;
    assign w_out_hs   = r_s2_vld && out_ready;
    assign w_last_pix = (r_pix_cnt == CNT_W'(PIX_PER_FRAME - 1));

    assign w_in_ext   = BUS_W'(in_data);
    assign w_bias_ext = BUS_W'(bias_q);

    for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
        logic [DATA_W-1:0] w_in_lane;
        logic [DATA_W-1:0] w_bias_lane;

        assign w_in_lane       = lane_slice(w_in_ext, g);
        assign w_bias_lane     = lane_slice(w_bias_ext, g);
        assign w_s1_sum_nxt[g] = {w_in_lane[DATA_W-1], w_in_lane}
                               + {w_bias_lane[DATA_W-1], w_bias_lane};

        bias_sat_lane #(
            .RELU_EN (RELU_EN)
        ) u_sat (
            .i_sum (r_s1_sum[g]),
            .o_dat (w_s2_dat_nxt[g*DATA_W +: DATA_W]),
            .o_sat (w_lane_sat[g])
        );
    end

    // Stage 1: capture widened sums whenever the slot is free or draining forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_sum <= '0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_sum <= w_s1_sum_nxt;
            end
        end
    end

    // Stage 2: hold saturated lanes and beat-level sat flag until the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_sat <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_dat <= w_s2_dat_nxt;
                r_s2_sat <= |w_lane_sat;
            end
        end
    end

    // Pixel counter wraps on the last output handshake of a frame and pulses frame_done next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_hs && w_last_pix;
            if (w_out_hs) begin
                r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
            end
        end
    end

    assign in_ready   = w_s1_adv && !rst;
    assign out_valid  = r_s2_vld;
    assign out_data   = r_s2_dat;
    assign sat_flag   = r_s2_sat;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bias_add_relu_stage.sv
// Bench for bias_add_relu_stage: ReLU and linear instances driven in lockstep against a queue model.
// Latency: model predicts per-beat results; directed steps pin timing with literals.
// Backpressure: exercised by stalling out_ready with a continuous input stream.
module tb_bias_add_relu_stage;

    localparam int N  = 16;
    localparam int W  = 18;
    localparam int BW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] bias_q = '0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;

    logic          rdy_r, rdy_l, ov_r, ov_l, sat_r, sat_l, fd_r, fd_l;
    logic [BW-1:0] od_r, od_l;

    always #5 clk = ~clk;

    bias_add_relu_stage #(.N_adder_tree(N), .DATA_W(W), .RELU_EN(1'b1), .PIX_PER_FRAME(4)) dut_r (
        .clk(clk), .rst(rst), .bias_q(bias_q), .in_valid(in_valid), .in_ready(rdy_r),
        .in_data(in_data), .out_valid(ov_r), .out_ready(out_ready), .out_data(od_r),
        .sat_flag(sat_r), .frame_done(fd_r));

    bias_add_relu_stage #(.N_adder_tree(N), .DATA_W(W), .RELU_EN(1'b0), .PIX_PER_FRAME(4)) dut_l (
        .clk(clk), .rst(rst), .bias_q(bias_q), .in_valid(in_valid), .in_ready(rdy_l),
        .in_data(in_data), .out_valid(ov_l), .out_ready(out_ready), .out_data(od_l),
        .sat_flag(sat_l), .frame_done(fd_l));

    typedef struct {
        logic [BW-1:0] dr;
        logic [BW-1:0] dl;
        logic          sr;
        logic          sl;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   mcnt = 0;
    int   n_out = 0;
    int   fd_pulses = 0;
    logic exp_fd = 1'b0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input logic [BW-1:0] v, input int i);
        return v[W*i +: W];
    endfunction

    // Plain signed arithmetic: add, clamp to the 18-bit range, optional ReLU.
    function automatic logic [BW-1:0] model(input logic [BW-1:0] d, input logic [BW-1:0] b,
                                            input bit relu, output logic sat);
        logic [BW-1:0] r;
        int            s;
        r   = '0;
        sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            s = $signed(d[W*i +: W]) + $signed(b[W*i +: W]);
            if (s > 131071) begin
                s = 131071;
                sat = 1'b1;
            end else if (s < -131072) begin
                s = -131072;
                sat = 1'b1;
            end
            if (relu && s < 0) s = 0;
            r[W*i +: W] = s[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] pat(input int k);
        logic [BW-1:0] r;
        for (int i = 0; i < N; i++) r[W*i +: W] = W'(k * 16 + i);
        return r;
    endfunction

    // Scoreboard: every cycle, compare outputs with the oldest outstanding beat and track handshakes.
    always @(negedge clk) begin
        logic hs_in;
        logic hs_out;
        exp_t e;
        if (rst) begin
            chki("in_ready_in_rst", int'(rdy_r), 0);
            q.delete();
            mcnt   = 0;
            exp_fd = 1'b0;
        end else begin
            chki("frame_done_r", int'(fd_r), int'(exp_fd));
            chki("frame_done_l", int'(fd_l), int'(exp_fd));
            if (fd_r) fd_pulses++;
            chki("in_ready", int'(rdy_r), int'(q.size() < 2 || out_ready));
            chki("out_valid_pair", int'(ov_l), int'(ov_r));
            if (q.size() == 0) begin
                chki("out_valid_empty", int'(ov_r), 0);
            end else if (ov_r) begin
                chk("out_data_relu", od_r, q[0].dr);
                chk("out_data_lin", od_l, q[0].dl);
                chki("sat_flag_relu", int'(sat_r), int'(q[0].sr));
                chki("sat_flag_lin", int'(sat_l), int'(q[0].sl));
            end
            hs_out = ov_r & out_ready;
            hs_in  = in_valid & rdy_r;
            exp_fd = hs_out && (mcnt == 3);
            if (hs_out) begin
                n_out++;
                if (q.size() > 0) void'(q.pop_front());
                mcnt = (mcnt + 1) % 4;
            end
            if (hs_in) begin
                e.dr = model(in_data, bias_q, 1'b1, e.sr);
                e.dl = model(in_data, bias_q, 1'b0, e.sl);
                q.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge, valid left high.
    task automatic send_beat(input logic [BW-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = rdy_r;
            @(posedge clk);
            #1;
        end
        chki("send_accept", int'(ok), 1);
    endtask

    task automatic send_and_wait(input logic [BW-1:0] d);
        send_beat(d);
        in_valid = 1'b0;
        @(negedge clk);
        chki("lat_s1_only", int'(ov_r), 0);
        @(negedge clk);
        chki("lat_out_valid", int'(ov_r), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, want finish");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] d;
        logic [BW-1:0] held;
        logic          rdy;
        int            k;
        int            n0;

        held = '0;
        bias_q[W*0 +: W] = 18'd100;
        bias_q[W*1 +: W] = 18'h3F9B0;
        bias_q[W*2 +: W] = 18'd100;
        bias_q[W*3 +: W] = 18'h3F9B0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chki("rst_out_valid", int'(ov_r), 0);
        chk("rst_out_data", od_r, '0);
        chki("rst_sat_flag", int'(sat_r), 0);
        chki("rst_frame_done", int'(fd_r), 0);
        chki("rst_in_ready", int'(rdy_r), 1);
        chki("rst_count", int'(dut_r.r_pix_cnt), 0);

        // Plain add and negative result with and without ReLU.
        @(posedge clk); #1;
        out_ready = 1'b1;
        d = '0;
        d[W*0 +: W] = 18'd50;
        d[W*1 +: W] = 18'd1000;
        send_and_wait(d);
        chki("t1_lane0", int'(lane(od_r, 0)), 150);
        chki("t2_lane1_relu", int'(lane(od_r, 1)), 0);
        chki("t2_lane1_lin", int'(lane(od_l, 1)), 'h3FD98);
        chki("t1_sat_relu", int'(sat_r), 0);
        chki("t1_sat_lin", int'(sat_l), 0);

        // Overflow clamps high.
        @(posedge clk); #1;
        d = '0;
        d[W*2 +: W] = 18'h1FFFF;
        send_and_wait(d);
        chki("t3_ovf_lane_relu", int'(lane(od_r, 2)), 'h1FFFF);
        chki("t3_ovf_lane_lin", int'(lane(od_l, 2)), 'h1FFFF);
        chki("t3_ovf_sat", int'(sat_r), 1);

        // Underflow clamps low; ReLU zeroes it but the flag survives.
        @(posedge clk); #1;
        d = '0;
        d[W*3 +: W] = 18'h20000;
        send_and_wait(d);
        chki("t3_unf_lane_lin", int'(lane(od_l, 3)), 'h20000);
        chki("t3_unf_sat_lin", int'(sat_l), 1);
        chki("t3_unf_lane_relu", int'(lane(od_r, 3)), 0);
        chki("t3_unf_sat_relu", int'(sat_r), 1);

        // Backpressure: stall output with a continuous input stream.
        @(posedge clk); #1;
        n0 = n_out;
        out_ready = 1'b0;
        k = 0;
        in_valid = 1'b1;
        in_data = pat(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rdy = rdy_r;
            if (c == 2) held = od_r;
            if (c > 2) chk("bp_hold_stable", od_r, held);
            @(posedge clk); #1;
            if (rdy) begin
                k++;
                in_data = pat(k);
            end
        end
        chki("bp_accepted", k, 2);
        @(negedge clk);
        chki("bp_in_ready_low", int'(rdy_r), 0);
        chki("bp_out_valid_held", int'(ov_r), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rdy = rdy_r;
            chki("bp_nogap", int'(ov_r), 1);
            @(posedge clk); #1;
            if (in_valid && rdy) begin
                k++;
                if (k == 8) in_valid = 1'b0;
                else in_data = pat(k);
            end
        end
        @(negedge clk);
        chki("bp_drained", int'(ov_r), 0);
        chki("bp_out_count", n_out - n0, 8);

        // Frame counting from a clean reset: 9 back-to-back beats, frame of 4.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        fd_pulses = 0;
        n0 = n_out;
        for (int j = 0; j < 9; j++) send_beat(pat(100 + j));
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chki("frame_pulses", fd_pulses, 2);
        chki("frame_out_count", n_out - n0, 9);
        chki("frame_count_end_r", int'(dut_r.r_pix_cnt), 1);
        chki("frame_count_end_l", int'(dut_l.r_pix_cnt), 1);

        // Reset with two beats stuck in the pipe.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_beat(pat(200));
        send_beat(pat(201));
        in_valid = 1'b0;
        chki("pre_rst_count", int'(dut_r.r_pix_cnt), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chki("mid_rst_out_valid", int'(ov_r), 0);
        chki("mid_rst_frame_done", int'(fd_r), 0);
        chki("mid_rst_count", int'(dut_r.r_pix_cnt), 0);
        chk("mid_rst_out_data", od_r, '0);
        chki("mid_rst_sat", int'(sat_r), 0);
        chki("mid_rst_in_ready", int'(rdy_r), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        d = '0;
        d[W*0 +: W] = 18'd50;
        send_and_wait(d);
        chki("post_rst_lane0", int'(lane(od_r, 0)), 150);
        chki("post_rst_lane1_lin", int'(lane(od_l, 1)), 'h3F9B0);

        @(posedge clk); #1;
        repeat (3) @(negedge clk);
        chki("final_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
